hash_target_checker: RTL and testbench

- Parametrised successor to the single-lane difficulty comparator in the hash-search datapath.
- Checks LANES hash/nonce pairs per cycle against an 8-bit target over the top BYTES_CHECK bytes.
- Queues qualifying (nonce, hash, lane) results in a small FIFO drained by a valid/ready handshake.
- Keeps saturating hit and drop counters. Sits between the hash cores and the result/report logic.

---
 rtl/hash_target_checker.sv | 171 +++++++++++++++++
 tb/tb_hash_target_checker.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hash_target_checker.sv
// Multi-lane hash difficulty checker: qualifies hashes against a target byte, queues winners in a
// small FIFO and counts hits/drops. Optional best-hash tracking is enabled with HTC_BEST_TRACK_EN.
module hash_target_checker #(
  parameter int HASH_W      = 24,
  parameter int NONCE_W     = 32,
  parameter int LANES       = 2,
  parameter int BYTES_CHECK = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 16,
  localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int LVL_W      = PTR_W + 1
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic [LANES-1:0]         in_valid,
  input  logic [LANES*HASH_W-1:0]  hash_in,
  input  logic [LANES*NONCE_W-1:0] nonce_in,
  input  logic [7:0]               target,
  input  logic                     fin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NONCE_W-1:0]       out_nonce,
  output logic [HASH_W-1:0]        out_hash,
  output logic [LANE_W-1:0]        out_lane,
  output logic [LVL_W-1:0]         fifo_level,
  output logic [CNT_W-1:0]         hit_count,
  output logic [CNT_W-1:0]         drop_count
`ifdef HTC_BEST_TRACK_EN
  ,
  output logic                     best_valid,
  output logic [HASH_W-1:0]        best_hash,
  output logic [NONCE_W-1:0]       best_nonce
`endif
);

  logic [LANES-1:0] hit;

  // Per-lane qualify: every checked top byte must be strictly below the target.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [BYTES_CHECK-1:0] byte_lt;
      for (genvar gk = 0; gk < BYTES_CHECK; gk++) begin : g_byte
        assign byte_lt[gk] = hash_in[gi*HASH_W + HASH_W-1-8*gk -: 8] < target;
      end
      assign hit[gi] = in_valid[gi] && !fin && (&byte_lt);
    end
  endgenerate

  logic               win;
  logic [LANE_W-1:0]  win_lane;
  logic [HASH_W-1:0]  win_hash;
  logic [NONCE_W-1:0] win_nonce;
  logic [3:0]         n_hits;

  // Scanning downward leaves the lowest hitting lane as the winner.
  always_comb begin
    win       = 1'b0;
    win_lane  = '0;
    win_hash  = '0;
    win_nonce = '0;
    n_hits    = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win       = 1'b1;
        win_lane  = LANE_W'(i);
        win_hash  = hash_in[i*HASH_W +: HASH_W];
        win_nonce = nonce_in[i*NONCE_W +: NONCE_W];
        n_hits    = n_hits + 4'd1;
      end
    end
  end

  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_next;
  logic [LVL_W-1:0] level, level_after_pop, level_next;
  logic             full, pop, push;
  logic [3:0]       drop_inc;

  assign full            = (level == LVL_W'(FIFO_DEPTH));
  assign out_valid       = (level != '0);
  assign pop             = out_valid && out_ready;
  assign push            = win && (!full || pop);
  assign level_after_pop = level - LVL_W'(pop);
  assign level_next      = level_after_pop + LVL_W'(push);
  assign rd_next         = rd_ptr + PTR_W'(pop);
  // Every hitting lane that is not pushed is a drop (losers plus a blocked winner).
  assign drop_inc        = n_hits - {3'b000, push};
  assign fifo_level      = level;

  logic [HASH_W-1:0]  hash_mem  [FIFO_DEPTH];
  logic [NONCE_W-1:0] nonce_mem [FIFO_DEPTH];
  logic [LANE_W-1:0]  lane_mem  [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (push) begin
      hash_mem[wr_ptr]  <= win_hash;
      nonce_mem[wr_ptr] <= win_nonce;
      lane_mem[wr_ptr]  <= win_lane;
    end
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      out_hash   <= '0;
      out_nonce  <= '0;
      out_lane   <= '0;
      hit_count  <= '0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr     <= rd_next;
      level      <= level_next;
      hit_count  <= sat_add(hit_count, {3'b000, push});
      drop_count <= sat_add(drop_count, drop_inc);
      // Head registers follow the next head entry; they hold when the FIFO goes empty.
      if (level_next != '0) begin
        if (push && level_after_pop == '0) begin
          out_hash  <= win_hash;
          out_nonce <= win_nonce;
          out_lane  <= win_lane;
        end else begin
          out_hash  <= hash_mem[rd_next];
          out_nonce <= nonce_mem[rd_next];
          out_lane  <= lane_mem[rd_next];
        end
      end
    end
  end

`ifdef HTC_BEST_TRACK_EN
  logic               cand_valid;
  logic [HASH_W-1:0]  cand_hash;
  logic [NONCE_W-1:0] cand_nonce;

  // Strict less-than while scanning upward keeps ties on the lowest lane.
  always_comb begin
    cand_valid = 1'b0;
    cand_hash  = '0;
    cand_nonce = '0;
    for (int i = 0; i < LANES; i++) begin
      if (in_valid[i] && !fin && (!cand_valid || hash_in[i*HASH_W +: HASH_W] < cand_hash)) begin
        cand_valid = 1'b1;
        cand_hash  = hash_in[i*HASH_W +: HASH_W];
        cand_nonce = nonce_in[i*NONCE_W +: NONCE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      best_valid <= 1'b0;
      best_hash  <= '0;
      best_nonce <= '0;
    end else if (cand_valid && (!best_valid || cand_hash < best_hash)) begin
      best_valid <= 1'b1;
      best_hash  <= cand_hash;
      best_nonce <= cand_nonce;
    end
  end
`endif

endmodule

// File: tb/tb_hash_target_checker.sv
// Directed bench for hash_target_checker at default parameters (LANES=2, HASH_W=24, depth 4).
module tb_hash_target_checker;
  logic        clk = 1'b0;
  logic        reset_L = 1'b1;
  logic [1:0]  in_valid = '0;
  logic [47:0] hash_in = '0;
  logic [63:0] nonce_in = '0;
  logic [7:0]  target = 8'h40;
  logic        fin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_nonce;
  logic [23:0] out_hash;
  logic [0:0]  out_lane;
  logic [2:0]  fifo_level;
  logic [15:0] hit_count, drop_count;
`ifdef HTC_BEST_TRACK_EN
  logic        best_valid;
  logic [23:0] best_hash;
  logic [31:0] best_nonce;
`endif

  int errors = 0;
  int checks = 0;

  hash_target_checker dut (
    .clk(clk), .reset_L(reset_L), .in_valid(in_valid), .hash_in(hash_in), .nonce_in(nonce_in),
    .target(target), .fin(fin), .out_valid(out_valid), .out_ready(out_ready),
    .out_nonce(out_nonce), .out_hash(out_hash), .out_lane(out_lane), .fifo_level(fifo_level),
    .hit_count(hit_count), .drop_count(drop_count)
`ifdef HTC_BEST_TRACK_EN
    , .best_valid(best_valid), .best_hash(best_hash), .best_nonce(best_nonce)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One input cycle: drive lanes, take an edge, then idle the lanes.
  task automatic cycle(input logic [1:0] v, input logic [23:0] h0, input logic [23:0] h1,
                       input logic [31:0] n0, input logic [31:0] n1);
    in_valid = v;
    hash_in  = {h1, h0};
    nonce_in = {n1, n0};
    tick();
    in_valid = '0;
    $display("cycle: valid=%b h0=%h h1=%h -> level=%0d hits=%0d drops=%0d", v, h0, h1,
             fifo_level, hit_count, drop_count);
  endtask

  task automatic test_reset();
    #1 reset_L = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    checks++; if (hit_count !== 16'd0 || drop_count !== 16'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", hit_count, drop_count); end
    checks++; if (out_hash !== 24'h0 || out_nonce !== 32'h0 || out_lane !== 1'b0) begin errors++; $display("FAIL reset_head: got %h/%h/%b expected zeros", out_hash, out_nonce, out_lane); end
    @(negedge clk); @(negedge clk);
    reset_L = 1'b1;
  endtask

  task automatic test_single_hit();
    cycle(2'b01, 24'h3F3FFF, 24'h000000, 32'hA0, 32'hB0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    checks++; if (out_hash !== 24'h3F3FFF || out_nonce !== 32'hA0 || out_lane !== 1'b0) begin errors++; $display("FAIL single_head: got %h/%h/%b expected 3f3fff/a0/0", out_hash, out_nonce, out_lane); end
    checks++; if (hit_count !== 16'd1) begin errors++; $display("FAIL single_hits: got %0d expected 1", hit_count); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL single_pop: got valid=%b level=%0d expected 0/0", out_valid, fifo_level); end
    checks++; if (out_hash !== 24'h3F3FFF) begin errors++; $display("FAIL single_hold: got %h expected 3f3fff", out_hash); end
  endtask

  task automatic test_no_hit();
    cycle(2'b01, 24'h403000, 24'h0, 32'h1, 32'h0);
    cycle(2'b01, 24'h304000, 24'h0, 32'h2, 32'h0);
    fin = 1'b1;
    cycle(2'b11, 24'h101000, 24'h101000, 32'h3, 32'h4);
    fin = 1'b0;
    target = 8'h00;
    cycle(2'b11, 24'h000000, 24'h000000, 32'h5, 32'h6);
    target = 8'h40;
    checks++; if (fifo_level !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL nohit_level: got %0d expected 0", fifo_level); end
    checks++; if (hit_count !== 16'd1 || drop_count !== 16'd0) begin errors++; $display("FAIL nohit_counts: got %0d/%0d expected 1/0", hit_count, drop_count); end
  endtask

  task automatic test_dual_hit();
    cycle(2'b11, 24'h100000, 24'h200000, 32'hC0, 32'hC1);
    checks++; if (out_hash !== 24'h100000 || out_lane !== 1'b0 || out_nonce !== 32'hC0) begin errors++; $display("FAIL dual_head: got %h/%b/%h expected 100000/0/c0", out_hash, out_lane, out_nonce); end
    checks++; if (drop_count !== 16'd1 || hit_count !== 16'd2) begin errors++; $display("FAIL dual_counts: got hits=%0d drops=%0d expected 2/1", hit_count, drop_count); end
    cycle(2'b10, 24'h0, 24'h111111, 32'h0, 32'hD1);
    checks++; if (fifo_level !== 3'd2 || out_hash !== 24'h100000) begin errors++; $display("FAIL dual_lane1: got level=%0d head=%h expected 2/100000", fifo_level, out_hash); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_hash !== 24'h111111 || out_lane !== 1'b1 || out_nonce !== 32'hD1) begin errors++; $display("FAIL dual_second: got %h/%b/%h expected 111111/1/d1", out_hash, out_lane, out_nonce); end
    tick();
    tick();
    out_ready = 1'b0;
    checks++; if (fifo_level !== 3'd0 || hit_count !== 16'd3) begin errors++; $display("FAIL dual_drain: got level=%0d hits=%0d expected 0/3", fifo_level, hit_count); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++)
      cycle(2'b01, 24'h010000 + 24'(i), 24'h0, 32'h100 + 32'(i), 32'h0);
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_level: got %0d expected 4", fifo_level); end
    checks++; if (drop_count !== 16'd2 || hit_count !== 16'd7) begin errors++; $display("FAIL full_counts: got hits=%0d drops=%0d expected 7/2", hit_count, drop_count); end
    checks++; if (out_hash !== 24'h010000 || out_nonce !== 32'h100) begin errors++; $display("FAIL full_head: got %h/%h expected 010000/100", out_hash, out_nonce); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp_hash [4];
    exp_hash[0] = 24'h010002; exp_hash[1] = 24'h010003; exp_hash[2] = 24'h0A0000; exp_hash[3] = 24'h0A0000;
    out_ready = 1'b1;
    cycle(2'b01, 24'h0A0000, 24'h0, 32'h1AA, 32'h0);
    checks++; if (fifo_level !== 3'd4 || hit_count !== 16'd8 || drop_count !== 16'd2) begin errors++; $display("FAIL b2b_push: got level=%0d hits=%0d drops=%0d expected 4/8/2", fifo_level, hit_count, drop_count); end
    checks++; if (out_hash !== 24'h010001) begin errors++; $display("FAIL b2b_head: got %h expected 010001", out_hash); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out_hash !== exp_hash[i] || fifo_level !== 3'(3 - i)) begin errors++; $display("FAIL b2b_drain%0d: got %h level=%0d expected %h level=%0d", i, out_hash, fifo_level, exp_hash[i], 3 - i); end
    end
    tick();
    out_ready = 1'b0;
    checks++; if (fifo_level !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty_ready: got level=%0d expected 0", fifo_level); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++)
      cycle(2'b01, 24'h020000 + 24'(i), 24'h0, 32'h200 + 32'(i), 32'h0);
    checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL mid_pre_level: got %0d expected 3", fifo_level); end
    @(negedge clk);
    reset_L = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL mid_reset_fifo: got valid=%b level=%0d expected 0/0", out_valid, fifo_level); end
    checks++; if (hit_count !== 16'd0 || drop_count !== 16'd0 || out_hash !== 24'h0) begin errors++; $display("FAIL mid_reset_state: got hits=%0d drops=%0d head=%h expected 0/0/0", hit_count, drop_count, out_hash); end
    @(negedge clk);
    reset_L = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_after: got %b expected 0", out_valid); end
  endtask

`ifdef HTC_BEST_TRACK_EN
  task automatic test_best();
    checks++; if (best_valid !== 1'b0 || best_hash !== 24'h0) begin errors++; $display("FAIL best_reset: got %b/%h expected 0/0", best_valid, best_hash); end
    target = 8'h00;
    cycle(2'b01, 24'h500000, 24'h0, 32'h1, 32'h0);
    checks++; if (best_valid !== 1'b1 || best_hash !== 24'h500000) begin errors++; $display("FAIL best_first: got %b/%h expected 1/500000", best_valid, best_hash); end
    cycle(2'b01, 24'h200000, 24'h0, 32'h2, 32'h0);
    cycle(2'b01, 24'h300000, 24'h0, 32'h3, 32'h0);
    checks++; if (best_hash !== 24'h200000 || best_nonce !== 32'h2) begin errors++; $display("FAIL best_min: got %h/%h expected 200000/2", best_hash, best_nonce); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL best_fifo: got %0d expected 0", fifo_level); end
    cycle(2'b11, 24'h100000, 24'h100000, 32'h7, 32'h8);
    checks++; if (best_hash !== 24'h100000 || best_nonce !== 32'h7) begin errors++; $display("FAIL best_tie: got %h/%h expected 100000/7", best_hash, best_nonce); end
    fin = 1'b1;
    cycle(2'b01, 24'h000001, 24'h0, 32'h9, 32'h0);
    fin = 1'b0;
    checks++; if (best_hash !== 24'h100000) begin errors++; $display("FAIL best_fin: got %h expected 100000", best_hash); end
    target = 8'h40;
  endtask
`endif

  initial begin
    test_reset();
    test_single_hit();
    test_no_hit();
    test_dual_hit();
    test_full();
    test_back_to_back();
    test_reset_mid();
`ifdef HTC_BEST_TRACK_EN
    test_best();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end
endmodule
